// File: rtl/pulp_level_shifter_clamp_seq.sv
// rtl/pulp_level_shifter_clamp_seq.sv - sequenced WIDTH-bit isolation clamp for a switchable power domain
//
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   in_i       bus from the switchable domain
//   out_o      bus into the always-on domain (in_i or CLAMP_VALUE)
//   iso_req_i  isolation request from the power manager (1 = isolate)
//   pwr_ok_i   source domain power-good (1 = powered)
//   iso_ack_o  fully isolated and settled
//   clamped_o  out_o is currently driven with CLAMP_VALUE
module pulp_level_shifter_clamp_seq #(
  parameter int unsigned            WIDTH         = 32,
  parameter logic [WIDTH-1:0]       CLAMP_VALUE   = '0,
  parameter int unsigned            SETTLE_CYCLES = 4,
  parameter int unsigned            CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  input  logic             iso_req_i,
  input  logic             pwr_ok_i,
  output logic             iso_ack_o,
  output logic             clamped_o
);

  typedef enum logic [1:0] {
    ST_ISOLATED     = 2'd0,
    ST_RELEASE_WAIT = 2'd1,
    ST_ACTIVE       = 2'd2,
    ST_CLAMP_WAIT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               iso_ack_q, iso_ack_d;
  logic               clamp;

  // Next-state logic. The counter only advances inside the two wait
  // states and is parked at zero everywhere else, so every wait state
  // starts from zero without an explicit clear on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_ISOLATED: begin
        if (!iso_req_i && pwr_ok_i) begin
          state_d = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        // Any renewed request or power drop abandons the release at once.
        if (iso_req_i || !pwr_ok_i) begin
          state_d = ST_ISOLATED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ACTIVE: begin
        // Power loss skips the clamp settle: the combinational clamp
        // already protects out_o in the cycle pwr_ok_i falls.
        if (!pwr_ok_i) begin
          state_d = ST_ISOLATED;
        end else if (iso_req_i) begin
          state_d = ST_CLAMP_WAIT;
        end
      end
      ST_CLAMP_WAIT: begin
        // Not abortable: always runs its full settle time.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ISOLATED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ISOLATED;
      end
    endcase
    iso_ack_d = (state_d == ST_ISOLATED);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_ISOLATED;
      cnt_q     <= '0;
      iso_ack_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iso_ack_q <= iso_ack_d;
    end
  end

  assign clamp = (state_q != ST_ACTIVE) | ~pwr_ok_i;

  // AND-OR mux so an unknown in_i is masked off while clamped.
  assign out_o     = (CLAMP_VALUE & {WIDTH{clamp}}) | (in_i & {WIDTH{~clamp}});
  assign clamped_o = clamp;
  assign iso_ack_o = iso_ack_q;

endmodule

// File: tb/tb_pulp_level_shifter_clamp_seq.sv
// tb/tb_pulp_level_shifter_clamp_seq.sv - randomized model-checked bench for pulp_level_shifter_clamp_seq
module tb_pulp_level_shifter_clamp_seq;

  localparam int unsigned S_A = 4;
  localparam int unsigned S_B = 1;
  localparam logic [31:0] CV_A = 32'h0000FFFF;
  localparam logic [0:0]  CV_B = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, iso_a, pwr_a, ack_a, clp_a;
  logic [31:0] in_a, out_a;
  logic        rst_b, iso_b, pwr_b, ack_b, clp_b;
  logic [0:0]  in_b, out_b;

  pulp_level_shifter_clamp_seq #(
    .WIDTH(32), .CLAMP_VALUE(CV_A), .SETTLE_CYCLES(S_A)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .in_i(in_a), .out_o(out_a),
    .iso_req_i(iso_a), .pwr_ok_i(pwr_a), .iso_ack_o(ack_a), .clamped_o(clp_a)
  );

  pulp_level_shifter_clamp_seq #(
    .WIDTH(1), .CLAMP_VALUE(CV_B), .SETTLE_CYCLES(S_B)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .in_i(in_b), .out_o(out_b),
    .iso_req_i(iso_b), .pwr_ok_i(pwr_b), .iso_ack_o(ack_b), .clamped_o(clp_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: where each instance is, plus how many wait cycles remain.
  typedef enum int {M_ISO, M_REL, M_ACT, M_CLW} mphase_t;
  mphase_t ph[2];
  int      left[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic iso,
                            input logic pwr, input int settle);
    if (!rst) begin
      ph[k] = M_ISO; left[k] = 0;
    end else begin
      case (ph[k])
        M_ISO: if (!iso && pwr) begin ph[k] = M_REL; left[k] = settle; end
        M_REL: begin
          if (iso || !pwr) ph[k] = M_ISO;
          else begin
            left[k]--;
            if (left[k] == 0) ph[k] = M_ACT;
          end
        end
        M_ACT: begin
          if (!pwr) ph[k] = M_ISO;
          else if (iso) begin ph[k] = M_CLW; left[k] = settle; end
        end
        default: begin
          left[k]--;
          if (left[k] == 0) ph[k] = M_ISO;
        end
      endcase
    end
  endtask

  task automatic check_all();
    logic pass_a, pass_b;
    pass_a = (ph[0] == M_ACT) && pwr_a;
    pass_b = (ph[1] == M_ACT) && pwr_b;
    chk("a_out",     out_a, pass_a ? in_a : CV_A);
    chk("a_clamped", 32'(clp_a), 32'(!pass_a));
    chk("a_ack",     32'(ack_a), 32'(ph[0] == M_ISO));
    chk("b_out",     32'(out_b), 32'(pass_b ? in_b : CV_B));
    chk("b_clamped", 32'(clp_b), 32'(!pass_b));
    chk("b_ack",     32'(ack_b), 32'(ph[1] == M_ISO));
  endtask

  // Advance one edge, update the model, check just after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a, iso_a, pwr_a, S_A);
    model_step(1, rst_b, iso_b, pwr_b, S_B);
    #1;
    check_all();
  endtask

  // Check combinational response to inputs just changed.
  task automatic settle();
    #1;
    check_all();
  endtask

  initial begin
    ph[0] = M_ISO; ph[1] = M_ISO; left[0] = 0; left[1] = 0;
    rst_a = 1'b0; iso_a = 1'b0; pwr_a = 1'b1; in_a = 32'hDEADBEEF;
    rst_b = 1'b0; iso_b = 1'b0; pwr_b = 1'b1; in_b = 1'b0;

    // Reset value
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", out_a, 32'h0000FFFF);
      chk("rst_ack", 32'(ack_a), 32'd1);
      chk("rst_clamped", 32'(clp_a), 32'd1);
    end
    rst_a = 1'b1;
    settle();
    tick();
    chk("rel_first_ack", 32'(ack_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_wait_out", out_a, 32'h0000FFFF);
    end
    tick();
    chk("rel_done_out", out_a, 32'hDEADBEEF);
    chk("rel_done_clamped", 32'(clp_a), 32'd0);

    // Full cycle with a one-cycle request
    in_a = 32'h12345678; settle();
    chk("pass_zero_latency", out_a, 32'h12345678);
    iso_a = 1'b1; settle();
    chk("iso_pre_edge_pass", out_a, 32'h12345678);
    tick();
    chk("iso_clamped", 32'(clp_a), 32'd1);
    iso_a = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("iso_wait_ack", 32'(ack_a), 32'd0);
    end
    tick();
    chk("iso_ack", 32'(ack_a), 32'd1);
    tick();
    chk("rerel_ack", 32'(ack_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rerel_clamped", 32'(clp_a), 32'd1);
    end
    tick();
    chk("rerel_pass", out_a, 32'h12345678);

    // Power loss from ACTIVE
    pwr_a = 1'b0; settle();
    chk("pwr_comb_out", out_a, 32'h0000FFFF);
    chk("pwr_comb_ack", 32'(ack_a), 32'd0);
    tick();
    chk("pwr_ack", 32'(ack_a), 32'd1);

    // Release abort by request, then by power loss
    for (int r = 0; r < 2; r++) begin
      pwr_a = 1'b1; iso_a = 1'b0; settle();
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("abort_pre_clamped", 32'(clp_a), 32'd1);
      end
      if (r == 0) iso_a = 1'b1; else pwr_a = 1'b0;
      settle();
      chk("abort_comb_out", out_a, 32'h0000FFFF);
      tick();
      chk("abort_ack", 32'(ack_a), 32'd1);
      chk("abort_out", out_a, 32'h0000FFFF);
    end

    // Reset during CLAMP_WAIT
    pwr_a = 1'b1; iso_a = 1'b0; settle();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_active", 32'(clp_a), 32'd0);
    iso_a = 1'b1; settle();
    tick(); tick();
    rst_a = 1'b0; settle();
    tick();
    chk("mid_rst_ack", 32'(ack_a), 32'd1);
    rst_a = 1'b1; iso_a = 1'b0; settle();

    // Single-cycle settle on the 1-bit instance
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iso_b = 1'((i / 2) % 2);
      in_b  = 1'($urandom_range(0, 1));
      settle();
      tick();
      chk("b_seq_ack", 32'(ack_b), 32'((i % 4) == 3));
      chk("b_seq_clamped", 32'(clp_b), 32'((i % 4) != 1));
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) iso_a = ~iso_a;
      if ($urandom_range(0, 3) == 0) iso_b = ~iso_b;
      pwr_a = ($urandom_range(0, 11) != 0);
      pwr_b = ($urandom_range(0, 11) != 0);
      rst_a = ($urandom_range(0, 59) != 0);
      rst_b = ($urandom_range(0, 59) != 0);
      in_a  = $urandom;
      in_b  = 1'($urandom_range(0, 1));
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
